// File: rtl/square_wave_generator.sv
// ---------------------------------------------------------------------------
// square_wave_generator
//
// Transmit-side counterpart of the rising-edge detection path. Generates a
// programmable square wave on data_out, clocked by sclk, to stimulate and
// loop back into an edge-detect receiver. A one-cycle strobe on edge_tx marks
// every 0->1 transition of data_out, so received edges can be lined up with
// sent edges. A start/busy/done handshake controls each run.
//
// Parameters
//   CNT_W       width of the high/low phase lengths (sclk cycles)
//   NCYC_W      width of the period count; 0 requests a continuous run
//
// Ports
//   sclk        in   1       clock, all logic on the rising edge
//   rst_n       in   1       asynchronous active-low reset
//   start       in   1       one-cycle run request, honoured only when idle
//   high_cnt    in   CNT_W   high-phase length in cycles (0 behaves as 1)
//   low_cnt     in   CNT_W   low-phase length in cycles (0 behaves as 1)
//   num_cycles  in   NCYC_W  number of full periods (0 = continuous)
//   stop        in   1       abort request, honoured while running
//   data_out    out  1       generated square wave (registered)
//   edge_tx     out  1       strobe in the first cycle data_out is 1 after 0
//   busy        out  1       high while in the HIGH or LOW phase
//   done        out  1       one-cycle strobe when a run ends (count or stop)
// ---------------------------------------------------------------------------
module square_wave_generator #(
  parameter int CNT_W  = 16,
  parameter int NCYC_W = 16
) (
  input  logic              sclk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  high_cnt,
  input  logic [CNT_W-1:0]  low_cnt,
  input  logic [NCYC_W-1:0] num_cycles,
  input  logic              stop,
  output logic              data_out,
  output logic              edge_tx,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_next;

  // Run parameters captured at start; they stay fixed for the whole run.
  logic [CNT_W-1:0]    r_high_len;
  logic [CNT_W-1:0]    r_low_len;
  logic [NCYC_W-1:0]   r_ncyc;

  // r_phase counts cycles already spent in the current phase (0-based), so
  // the last cycle of a phase of length N is r_phase == N-1. This lets a
  // length of 2^CNT_W-1 be reached without the counter ever wrapping.
  logic [CNT_W-1:0]    r_phase;
  // Completed periods of the current run; free to wrap in continuous mode.
  logic [NCYC_W-1:0]   r_cyc;

  logic                r_data_out;
  logic                r_edge_tx;
  logic                r_busy;
  logic                r_done;

  logic [CNT_W-1:0]    w_high_in;
  logic [CNT_W-1:0]    w_low_in;
  logic                w_high_last;
  logic                w_low_last;
  logic [NCYC_W-1:0]   w_cyc_inc;
  logic                w_run_end;
  logic                w_accept;
  logic                w_period_end;

  logic                w_data_out_next;
  logic                w_edge_tx_next;
  logic                w_busy_next;
  logic                w_done_next;

  // Zero-length phases behave as one cycle.
  assign w_high_in    = (high_cnt == '0) ? CNT_W'(1) : high_cnt;
  assign w_low_in     = (low_cnt  == '0) ? CNT_W'(1) : low_cnt;

  assign w_high_last  = (r_phase == (r_high_len - CNT_W'(1)));
  assign w_low_last   = (r_phase == (r_low_len  - CNT_W'(1)));

  // A counted run ends when the period that is just finishing brings the
  // completed-period count up to the requested number. A request of 0 never
  // matches, which is what makes the run continuous.
  assign w_cyc_inc    = r_cyc + NCYC_W'(1);
  assign w_run_end    = (r_ncyc != '0) && (w_cyc_inc == r_ncyc);

  assign w_accept     = (r_state == S_IDLE) && start;
  assign w_period_end = (r_state == S_LOW) && w_low_last && !stop;

  // -------------------------------------------------------------------------
  // State register, including the registered outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_data_out <= 1'b0;
      r_edge_tx  <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_data_out <= w_data_out_next;
      r_edge_tx  <= w_edge_tx_next;
      r_busy     <= w_busy_next;
      r_done     <= w_done_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic. stop takes priority over any phase or period end that
  // falls in the same cycle; start is only looked at when idle, so a stop
  // arriving together with start in IDLE has no effect.
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = S_HIGH;
        end
      end
      S_HIGH: begin
        if (stop) begin
          w_state_next = S_IDLE;
        end else if (w_high_last) begin
          w_state_next = S_LOW;
        end
      end
      S_LOW: begin
        if (stop) begin
          w_state_next = S_IDLE;
        end else if (w_low_last) begin
          w_state_next = w_run_end ? S_IDLE : S_HIGH;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Output logic. Outputs are registered, so their next values are derived
  // from the state being entered. edge_tx fires only on entry into HIGH, and
  // done only on entry into IDLE from a running state; the two can therefore
  // never coincide.
  // -------------------------------------------------------------------------
  always_comb begin
    w_data_out_next = 1'b0;
    w_edge_tx_next  = 1'b0;
    w_busy_next     = 1'b0;
    w_done_next     = 1'b0;
    if (w_state_next == S_HIGH) begin
      w_data_out_next = 1'b1;
      w_edge_tx_next  = (r_state != S_HIGH);
    end
    if (w_state_next != S_IDLE) begin
      w_busy_next = 1'b1;
    end
    if ((r_state != S_IDLE) && (w_state_next == S_IDLE)) begin
      w_done_next = 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Run parameters and counters
  // -------------------------------------------------------------------------
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      r_high_len <= '0;
      r_low_len  <= '0;
      r_ncyc     <= '0;
    end else if (w_accept) begin
      r_high_len <= w_high_in;
      r_low_len  <= w_low_in;
      r_ncyc     <= num_cycles;
    end
  end

  // The phase counter restarts on every state change (including entry into
  // HIGH from IDLE) and otherwise advances while a phase is running.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase <= '0;
    end else if (w_state_next != r_state) begin
      r_phase <= '0;
    end else if (r_state != S_IDLE) begin
      r_phase <= r_phase + CNT_W'(1);
    end
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      r_cyc <= '0;
    end else if (w_accept) begin
      r_cyc <= '0;
    end else if (w_period_end) begin
      r_cyc <= w_cyc_inc;
    end
  end

  assign data_out = r_data_out;
  assign edge_tx  = r_edge_tx;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: tb/tb_square_wave_generator.sv
module tb_square_wave_generator;

  localparam int CNT_W  = 4;
  localparam int NCYC_W = 4;

  logic              sclk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              stop;
  logic [CNT_W-1:0]  high_cnt;
  logic [CNT_W-1:0]  low_cnt;
  logic [NCYC_W-1:0] num_cycles;
  logic              data_out;
  logic              edge_tx;
  logic              busy;
  logic              done;

  int checks = 0;
  int errors = 0;

  // Expected per-cycle outputs; index 0 is the cycle start is driven in.
  bit exp_d[$];
  bit exp_e[$];
  bit exp_b[$];
  bit exp_dn[$];

  square_wave_generator #(.CNT_W(CNT_W), .NCYC_W(NCYC_W)) dut (
    .sclk       (sclk),
    .rst_n      (rst_n),
    .start      (start),
    .high_cnt   (high_cnt),
    .low_cnt    (low_cnt),
    .num_cycles (num_cycles),
    .stop       (stop),
    .data_out   (data_out),
    .edge_tx    (edge_tx),
    .busy       (busy),
    .done       (done)
  );

  always #5 sclk = ~sclk;

  // Minimal edge-detect receiver for loopback: registered rising-edge strobe.
  logic rx_prev;
  logic rx_rise;
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      rx_prev <= 1'b0;
      rx_rise <= 1'b0;
    end else begin
      rx_prev <= data_out;
      rx_rise <= data_out & ~rx_prev;
    end
  end

  task automatic chk(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, expv);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic push(input bit d, input bit e, input bit b, input bit dn);
    exp_d.push_back(d);
    exp_e.push_back(e);
    exp_b.push_back(b);
    exp_dn.push_back(dn);
  endtask

  // Waveform from the rules: each period is H high cycles (edge on the first)
  // then L low cycles; a run ends after N periods or one cycle after stop,
  // followed by a single done cycle.
  task automatic build(input int h, input int l, input int n, input int stop_at);
    int hh, ll, periods, limit;
    exp_d.delete(); exp_e.delete(); exp_b.delete(); exp_dn.delete();
    push(0, 0, 0, 0);
    hh      = (h == 0) ? 1 : h;
    ll      = (l == 0) ? 1 : l;
    periods = (n == 0) ? 1000 : n;
    limit   = (stop_at > 0) ? stop_at : 100000;
    for (int p = 0; p < periods && exp_d.size() <= limit; p++) begin
      for (int i = 0; i < hh; i++) push(1, i == 0, 1, 0);
      for (int i = 0; i < ll; i++) push(0, 0, 1, 0);
    end
    if (stop_at > 0) begin
      while (exp_d.size() > stop_at + 1) begin
        void'(exp_d.pop_back()); void'(exp_e.pop_back());
        void'(exp_b.pop_back()); void'(exp_dn.pop_back());
      end
    end
    push(0, 0, 0, 1);
    push(0, 0, 0, 0);
    push(0, 0, 0, 0);
  endtask

  // Entered and left at 1 time unit after a rising edge with the DUT idle.
  task automatic run_case(input string name, input int h, input int l, input int n,
                          input int stop_at, input int mid_start, input bit co_stop,
                          input bit loopback);
    int n_edge_exp, n_edge_obs, n_rx_obs;
    build(h, l, n, stop_at);
    high_cnt   = CNT_W'(h);
    low_cnt    = CNT_W'(l);
    num_cycles = NCYC_W'(n);
    start      = 1'b1;
    stop       = co_stop;
    n_edge_exp = 0;
    n_edge_obs = 0;
    n_rx_obs   = 0;
    foreach (exp_e[i]) n_edge_exp += exp_e[i];
    for (int t = 1; t < exp_d.size(); t++) begin
      @(posedge sclk);
      #1;
      start = 1'b0;
      stop  = 1'b0;
      if (t < exp_d.size() - 3) begin
        // Inputs wander mid-run; the latched run parameters must not follow.
        high_cnt   = CNT_W'($urandom);
        low_cnt    = CNT_W'($urandom);
        num_cycles = NCYC_W'($urandom);
        if (t == mid_start) start = 1'b1;
      end
      if (t == stop_at) stop = 1'b1;
      chk({name, ".data_out"}, data_out, exp_d[t]);
      chk({name, ".edge_tx"},  edge_tx,  exp_e[t]);
      chk({name, ".busy"},     busy,     exp_b[t]);
      chk({name, ".done"},     done,     exp_dn[t]);
      if (loopback) chk({name, ".rx_rise"}, rx_rise, exp_e[t-1]);
      n_edge_obs += int'(edge_tx);
      n_rx_obs   += int'(rx_rise);
    end
    chk_int({name, ".edge_count"}, n_edge_obs, n_edge_exp);
    if (loopback) chk_int({name, ".rx_count"}, n_rx_obs, n_edge_exp);
  endtask

  initial begin
    int h, l, n, a, sa, ms;
    rst_n      = 1'b0;
    start      = 1'b0;
    stop       = 1'b0;
    high_cnt   = '0;
    low_cnt    = '0;
    num_cycles = '0;

    // Reset held with start toggling.
    for (int i = 0; i < 4; i++) begin
      @(posedge sclk);
      #1;
      start      = ~start;
      high_cnt   = 4'd3;
      num_cycles = 4'd2;
      chk("reset.data_out", data_out, 1'b0);
      chk("reset.edge_tx",  edge_tx,  1'b0);
      chk("reset.busy",     busy,     1'b0);
      chk("reset.done",     done,     1'b0);
    end
    start = 1'b0;
    @(posedge sclk);
    #1;
    rst_n = 1'b1;

    // stop while idle is ignored.
    stop = 1'b1;
    @(posedge sclk);
    #1;
    stop = 1'b0;
    chk("idle_stop.busy", busy, 1'b0);
    chk("idle_stop.done", done, 1'b0);
    chk("idle_stop.data_out", data_out, 1'b0);

    run_case("basic",     3, 2, 2,  0, 0, 1'b0, 1'b0);
    run_case("zero_len",  0, 0, 4,  0, 0, 1'b0, 1'b0);
    run_case("abort",     5, 5, 0, 13, 0, 1'b0, 1'b0);
    run_case("busy_start",3, 4, 3,  0, 5, 1'b0, 1'b0);
    run_case("loopback",  4, 4, 10, 0, 0, 1'b0, 1'b1);
    run_case("max_len",  15, 15, 1, 0, 0, 1'b0, 1'b0);
    run_case("max_ncyc",  1, 2, 15, 0, 0, 1'b0, 1'b0);
    run_case("start_stop",2, 1, 2,  0, 0, 1'b1, 1'b0);
    run_case("cont_wrap", 1, 1, 0, 40, 0, 1'b0, 1'b1);
    run_case("stop_at_end", 2, 3, 2, 10, 0, 1'b0, 1'b0);

    for (int k = 0; k < 20; k++) begin
      h  = $urandom_range(0, 7);
      l  = $urandom_range(0, 7);
      n  = $urandom_range(1, 5);
      a  = n * (((h == 0) ? 1 : h) + ((l == 0) ? 1 : l));
      sa = ($urandom_range(0, 2) == 0) ? $urandom_range(1, a) : 0;
      ms = $urandom_range(1, a);
      run_case("random", h, l, n, sa, ms, 1'($urandom_range(0, 1)), 1'b1);
    end

    // Reset in the middle of a run: immediate return to idle, no done.
    high_cnt   = 4'd5;
    low_cnt    = 4'd5;
    num_cycles = 4'd0;
    start      = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(posedge sclk);
      #1;
      start = 1'b0;
    end
    chk("midrst.busy_before", busy, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst.data_out", data_out, 1'b0);
    chk("midrst.busy",     busy,     1'b0);
    chk("midrst.done",     done,     1'b0);
    @(posedge sclk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge sclk);
      #1;
      chk("midrst.after_done", done, 1'b0);
      chk("midrst.after_busy", busy, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety net against a hang.
  initial begin
    #400000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
